// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, loader/DMA port, shared memory
// port and status. The arbiter uses the slave view; the environment uses master.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          last_grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we,
    output busy, last_grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, last_grant
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / loader) round-robin arbiter in front of a single data memory.
// Each granted access is latched and held for ACCESS_CYCLES cycles before completing.
module data_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          final_cyc;

  // Completion is suppressed while Reset is low so an abandoned access never
  // pulses ack or writes memory, even in its would-be final cycle.
  assign final_cyc = (state_q != IDLE) && (cnt_q == 4'd0) && Reset;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        // On a tie the CPU wins only if the DMA owned the last access.
        if (bus.cpu_req && (!bus.dma_req || last_grant_q)) begin
          state_d = CPU_ACC;
          cnt_d   = CNT_LOAD;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
        end else if (bus.dma_req) begin
          state_d = DMA_ACC;
          cnt_d   = CNT_LOAD;
          we_d    = bus.dma_we;
          addr_d  = bus.dma_addr;
          wdata_d = bus.dma_wdata;
        end
      end
      CPU_ACC, DMA_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d      = IDLE;
          last_grant_d = (state_q == DMA_ACC);
          if (!we_q) begin
            if (state_q == DMA_ACC) dma_rdata_d = bus.mem_rdata;
            else                    cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = final_cyc && we_q;
  assign bus.cpu_ack    = final_cyc && (state_q == CPU_ACC);
  assign bus.dma_ack    = final_cyc && (state_q == DMA_ACC);
  assign bus.cpu_stall  = bus.cpu_req && !(final_cyc && (state_q == CPU_ACC));
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.last_grant = last_grant_q;
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, data width; ACCESS_CYCLES, 1, memory cycles per access (legal 1..15).
REQ-002 Port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port Reset  input  1  synchronous, active-low reset.
REQ-004 Port cpu_req / cpu_we  input  1 / 1  CPU access request and write qualifier.
REQ-005 Port cpu_addr / cpu_wdata  input  AW / DW  CPU address and write data.
REQ-006 Port cpu_rdata  output  DW  CPU read data, registered.
REQ-007 Port cpu_ack / cpu_stall  output  1 / 1  CPU completion pulse; stall to the multi-cycle control FSM.
REQ-008 Port dma_req / dma_we  input  1 / 1  loader/DMA request and write qualifier.
REQ-009 Port dma_addr / dma_wdata  input  AW / DW  loader address and write data.
REQ-010 Port dma_rdata / dma_ack  output  DW / 1  loader read data (registered) and completion pulse.
REQ-011 Port mem_addr / mem_wdata  output  AW / DW  shared data-memory address and write data.
REQ-012 Port mem_we  output  1  shared data-memory write enable (memory writes on CLK edge).
REQ-013 Port mem_rdata  input  DW  shared data-memory combinational read data.
REQ-014 Port busy / last_grant  output  1 / 1  access in flight; owner of last completed access (0 = CPU, 1 = DMA).

Function
REQ-015 FSM SHALL have states IDLE, CPU_ACC, DMA_ACC.
REQ-016 In IDLE with exactly one req high, the FSM SHALL enter that requester's ACC state on the next edge.
REQ-017 In IDLE with both reqs high, the FSM SHALL grant the requester not equal to last_grant (round-robin).
REQ-018 On ACC entry the arbiter SHALL latch addr, wdata and we of the granted requester; requester inputs are ignored thereafter until completion.
REQ-019 A 4-bit cycle counter SHALL load ACCESS_CYCLES-1 on ACC entry and decrement each ACC cycle; the cycle with counter = 0 is the final cycle.
REQ-020 mem_addr and mem_wdata SHALL drive the latched values during ACC and hold their last value in IDLE.
REQ-021 mem_we SHALL be high only in the final ACC cycle of a latched write, and only while Reset is high (one pulse per write).
REQ-022 In the final cycle the granted port's ack SHALL pulse high for exactly one cycle, and for reads mem_rdata SHALL be captured into that port's rdata at the same edge.
REQ-023 rdata registers SHALL hold until the next read completion on the same port; writes SHALL NOT change rdata.
REQ-024 After the final cycle the FSM SHALL return to IDLE; minimum spacing between grants SHALL be ACCESS_CYCLES+1 cycles.
REQ-025 last_grant SHALL update at the final-cycle edge.
REQ-026 busy SHALL be high exactly when state is CPU_ACC or DMA_ACC.
REQ-027 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-028 A requester dropping req before ack SHALL NOT abort the access; the latched access completes and ack still pulses.
REQ-029 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-030 Requesters SHALL hold req and operands stable until ack; the arbiter is not required to detect violations.

Reset
REQ-031 When Reset is sampled low: state=IDLE, counter=0, last_grant=1 (CPU wins first tie), cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, mem_addr=mem_wdata=0, busy=0.
REQ-032 Reset asserted mid-access SHALL abandon the access: no ack and no mem_we pulse for it, including when Reset is low in the would-be final cycle.
REQ-033 First grant after reset release SHALL be decided on the first edge with Reset high.

Verification
REQ-034 ACCESS_CYCLES=1, CPU write addr 0x10 data 0xDEADBEEF -> mem_we one cycle with mem_addr 0x10, cpu_ack one cycle later than req, cpu_stall high for exactly 1 cycle.
REQ-035 ACCESS_CYCLES=3, both reqs high from reset release (CPU read 0x20, DMA write 0x24 data 0x5) -> CPU served first (ack at cycle 3), DMA ack at cycle 7, last_grant=1 after.
REQ-036 Both requesters hold req continuously for 8 accesses -> grants strictly alternate CPU, DMA, CPU, ...; no starvation.
REQ-037 ACCESS_CYCLES=3, DMA write in flight, Reset low in its 2nd ACC cycle -> no mem_we pulse, no dma_ack, all outputs at reset values next cycle.
REQ-038 CPU read with mem_rdata=0xCAFEF00D, then CPU write -> cpu_rdata=0xCAFEF00D after first ack and unchanged after second.
REQ-039 DMA drops req one cycle after grant -> access completes, dma_ack pulses once, FSM returns to IDLE.
